fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: reads two-word instructions from a synchronous RAM port
// and buffers them in a small circular queue, with redirect (flush + restart) support.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clka,
    input  logic        rst,
    output logic        enb,
    output logic [9:0]  addrb,
    input  logic [15:0] dob,
    input  logic        redirect,
    input  logic [9:0]  redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  inst_op,
    output logic [7:0]  inst_regnum,
    output logic [15:0] inst_num,
    output logic [9:0]  inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 16 + 16 + 10;

    typedef enum logic [1:0] {S_W0, S_W1, S_HOLD} state_t;

    state_t          state_reg, state_next;
    logic [9:0]      pc_reg, pc_next;
    logic [15:0]     word0_reg, word0_next;
    logic [9:0]      word0_pc_reg, word0_pc_next;
    logic            push_pending_reg, push_pending_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;

    logic [CW:0]     occupancy;
    logic            space;
    logic            push;
    logic            pop;
    logic [EW-1:0]   entry_q [DEPTH];
    logic [EW-1:0]   head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pending push is counted as occupied; a same-cycle pop is deliberately not credited.
    assign occupancy  = {1'b0, count_reg} + {{CW{1'b0}}, push_pending_reg};
    assign space      = occupancy < (CW + 1)'(DEPTH);
    assign inst_valid = (count_reg != '0);
    assign push       = push_pending_reg && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_reg        <= S_W0;
            pc_reg           <= '0;
            word0_reg        <= '0;
            word0_pc_reg     <= '0;
            push_pending_reg <= 1'b0;
            count_reg        <= '0;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            word0_reg        <= word0_next;
            word0_pc_reg     <= word0_pc_next;
            push_pending_reg <= push_pending_next;
            count_reg        <= count_next;
            rd_ptr_reg       <= rd_ptr_next;
            wr_ptr_reg       <= wr_ptr_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        word0_next        = word0_reg;
        word0_pc_next     = word0_pc_reg;
        push_pending_next = 1'b0;
        count_next        = count_reg;
        rd_ptr_next       = rd_ptr_reg;
        wr_ptr_next       = wr_ptr_reg;
        enb               = 1'b0;
        addrb             = pc_reg;

        case (state_reg)
            S_W0: begin
                if (space) begin
                    enb        = 1'b1;
                    state_next = S_W1;
                end else begin
                    state_next = S_HOLD;
                end
            end
            S_W1: begin
                // dob now carries word0; word1 arrives next cycle and is pushed then.
                enb               = 1'b1;
                addrb             = pc_reg + 10'd1;
                word0_next        = dob;
                word0_pc_next     = pc_reg;
                pc_next           = pc_reg + 10'd2;
                push_pending_next = 1'b1;
                state_next        = S_W0;
            end
            S_HOLD: begin
                if (space) begin
                    state_next = S_W0;
                end
            end
            default: state_next = S_W0;
        endcase

        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase

        // Redirect overrides everything, including the in-flight instruction.
        if (redirect) begin
            state_next        = S_W0;
            pc_next           = redirect_pc;
            push_pending_next = 1'b0;
            count_next        = '0;
            rd_ptr_next       = '0;
            wr_ptr_next       = '0;
        end

        if (rst) begin
            enb   = 1'b0;
            addrb = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;

            always_ff @(posedge clka or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg <= {word0_reg, dob, word0_pc_reg};
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign head        = entry_q[rd_ptr_reg];
    assign inst_op     = head[41:34];
    assign inst_regnum = head[33:26];
    assign inst_num    = head[25:10];
    assign inst_pc     = head[9:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: RAM model on port b, hand-computed vectors,
// and an in-order delivery check against the bench's own RAM image.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clka = 1'b0;
    logic        rst;
    logic        enb;
    logic [9:0]  addrb;
    logic [15:0] dob;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_op;
    logic [7:0]  inst_regnum;
    logic [15:0] inst_num;
    logic [9:0]  inst_pc;

    logic [15:0] ram [1024];

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clka        (clka),
        .rst         (rst),
        .enb         (enb),
        .addrb       (addrb),
        .dob         (dob),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_op     (inst_op),
        .inst_regnum (inst_regnum),
        .inst_num    (inst_num),
        .inst_pc     (inst_pc)
    );

    always #5 clka = ~clka;

    // Synchronous-read RAM: data valid in the cycle after the sampling edge.
    always @(posedge clka) begin
        if (enb) dob <= ram[addrb];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c = 0;
        while (!inst_valid && c < budget) begin
            @(negedge clka);
            c++;
        end
        check(tag, 32'(inst_valid), 32'd1);
    endtask

    // Pops instructions in pc order from start_pc, comparing the head whenever valid.
    task automatic run_stream(input logic [9:0] start_pc, input int n_inst,
                              input int budget, input bit rnd);
        logic [9:0]  exp_pc;
        logic [9:0]  p1;
        int          got;
        int          cyc;
        exp_pc = start_pc;
        got    = 0;
        cyc    = 0;
        while (cyc < budget && (rnd || got < n_inst)) begin
            @(negedge clka);
            inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inst_valid) begin
                p1 = exp_pc + 10'd1;
                check("stream_pc",     32'(inst_pc),     32'(exp_pc));
                check("stream_op",     32'(inst_op),     32'(ram[exp_pc][15:8]));
                check("stream_regnum", 32'(inst_regnum), 32'(ram[exp_pc][7:0]));
                check("stream_num",    32'(inst_num),    32'(ram[p1]));
                if (inst_ready) begin
                    $display("deliver pc=0x%03h op=0x%02h reg=0x%02h num=0x%04h",
                             inst_pc, inst_op, inst_regnum, inst_num);
                    exp_pc = exp_pc + 10'd2;
                    got++;
                end
            end
            cyc++;
        end
        check("stream_count_ok", 32'(got >= n_inst), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        for (int a = 0; a < 1024; a++) begin
            v = (a * 40503) ^ 32'h1D2B;
            ram[a] = v[15:0];
        end
        ram[0] = 16'h0401;
        ram[1] = 16'h1234;

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b1;
        dob         = '0;

        // Reset state
        repeat (3) @(negedge clka);
        check("rst_enb",    32'(enb),         32'd0);
        check("rst_addrb",  32'(addrb),       32'd0);
        check("rst_valid",  32'(inst_valid),  32'd0);
        check("rst_op",     32'(inst_op),     32'd0);
        check("rst_regnum", 32'(inst_regnum), 32'd0);
        check("rst_num",    32'(inst_num),    32'd0);
        check("rst_pc",     32'(inst_pc),     32'd0);

        // First instruction latency after reset release
        rst = 1'b0;
        #1;
        check("rel_enb",   32'(enb),   32'd1);
        check("rel_addrb", 32'(addrb), 32'd0);
        @(negedge clka);
        check("w1_enb",   32'(enb),   32'd1);
        check("w1_addrb", 32'(addrb), 32'd1);
        @(negedge clka);
        check("lat_not_yet", 32'(inst_valid), 32'd0);
        @(negedge clka);
        check("first_valid",  32'(inst_valid),  32'd1);
        check("first_op",     32'(inst_op),     32'h04);
        check("first_regnum", 32'(inst_regnum), 32'h01);
        check("first_num",    32'(inst_num),    32'h1234);
        check("first_pc",     32'(inst_pc),     32'd0);

        // Fill with consumer stalled, then drain in order
        rst = 1'b1;
        inst_ready = 1'b0;
        @(negedge clka);
        rst = 1'b0;
        repeat (20) @(negedge clka);
        check("full_valid", 32'(inst_valid), 32'd1);
        check("full_pc",    32'(inst_pc),    32'd0);
        check("hold_enb",   32'(enb),        32'd0);
        check("hold_addrb", 32'(addrb),      32'd8);
        repeat (3) @(negedge clka);
        check("hold_pc_stable", 32'(inst_pc), 32'd0);
        check("hold_op_stable", 32'(inst_op), 32'h04);
        run_stream(10'd0, 8, 100, 1'b0);

        // Redirect with 3 entries queued, coincident with a pop
        @(negedge clka);
        rst = 1'b1;
        inst_ready = 1'b0;
        @(negedge clka);
        rst = 1'b0;
        repeat (7) @(negedge clka);
        check("pre_redir_valid", 32'(inst_valid), 32'd1);
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 10'h100;
        @(negedge clka);
        redirect = 1'b0;
        check("redir_valid", 32'(inst_valid), 32'd0);
        check("redir_enb",   32'(enb),        32'd1);
        check("redir_addrb", 32'(addrb),      32'h100);
        run_stream(10'h100, 4, 60, 1'b0);

        // Address wrap at 1023
        @(negedge clka);
        ram[1023]   = 16'h0102;
        ram[0]      = 16'hBEEF;
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 10'd1023;
        @(negedge clka);
        redirect = 1'b0;
        check("wrap_addrb", 32'(addrb), 32'd1023);
        wait_valid("wrap_valid", 10);
        check("wrap_op",     32'(inst_op),     32'h01);
        check("wrap_regnum", 32'(inst_regnum), 32'h02);
        check("wrap_num",    32'(inst_num),    32'hBEEF);
        check("wrap_pc",     32'(inst_pc),     32'd1023);
        inst_ready = 1'b1;
        @(negedge clka);
        inst_ready = 1'b0;
        wait_valid("wrap_next_valid", 10);
        check("wrap_next_pc", 32'(inst_pc), 32'd1);
        check("wrap_next_op", 32'(inst_op), 32'h12);

        // Reset pulsed while in S_W1 with two entries queued
        @(negedge clka);
        rst = 1'b1;
        @(negedge clka);
        rst = 1'b0;
        repeat (5) @(negedge clka);
        check("w1q_valid", 32'(inst_valid), 32'd1);
        check("w1q_enb",   32'(enb),        32'd1);
        check("w1q_addrb", 32'(addrb),      32'd5);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(inst_valid), 32'd0);
        check("abort_enb",   32'(enb),        32'd0);
        check("abort_addrb", 32'(addrb),      32'd0);
        check("abort_pc",    32'(inst_pc),    32'd0);
        @(negedge clka);
        rst = 1'b0;
        #1;
        check("restart_enb",   32'(enb),   32'd1);
        check("restart_addrb", 32'(addrb), 32'd0);
        run_stream(10'd0, 3, 40, 1'b0);

        // Random consumer backpressure across the address wrap
        @(negedge clka);
        redirect    = 1'b1;
        redirect_pc = 10'h3F0;
        @(negedge clka);
        redirect = 1'b0;
        run_stream(10'h3F0, 100, 500, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
